// File: rtl/counter_pkg.sv
// Shared types for the programmable modulus counter: FSM state and mode encodings.
package counter_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/prog_mod_counter_if.sv
// Control/status bundle of prog_mod_counter; master drives controls, slave is the counter.
interface prog_mod_counter_if #(
  parameter int unsigned N = 8
) ();

  logic         en;
  logic         up;
  logic         clr;
  logic         load;
  logic [N-1:0] load_val;
  logic         m_wr;
  logic [N-1:0] m_val;
  logic         mode;
  logic         start;
  logic [N-1:0] q;
  logic [N-1:0] m_cur;
  logic         max_tick;
  logic         term_tick;
  logic         busy;

  modport master (
    output en, up, clr, load, load_val, m_wr, m_val, mode, start,
    input  q, m_cur, max_tick, term_tick, busy
  );

  modport slave (
    input  en, up, clr, load, load_val, m_wr, m_val, mode, start,
    output q, m_cur, max_tick, term_tick, busy
  );

endinterface

// File: rtl/prog_mod_counter.sv
// Run-time programmable mod-M up/down counter with shadowed modulus, one-shot mode
// and a cascadable terminal tick.
module prog_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned M_DEFAULT = 10
) (
  input logic              clk,
  input logic              reset,
  prog_mod_counter_if.slave bus
);

  localparam logic [N-1:0] M_RST = N'(M_DEFAULT);

  if (M_DEFAULT == 0 || (64'(M_DEFAULT) >> N) != 64'd0) begin : g_bad_m_default
    $error("prog_mod_counter: M_DEFAULT must lie in 1..2^N-1");
  end

  logic [N-1:0] q_q, q_d;
  logic [N-1:0] m_cur_q, m_cur_d;
  logic [N-1:0] m_pend_q, m_pend_d;
  state_e       state_q, state_d;

  logic         wr_ok;
  logic [N-1:0] m_next;
  logic [N-1:0] m_last;
  logic [N-1:0] term_val;
  logic [N-1:0] load_clamped;
  logic         at_term;
  logic         commit;

  function automatic logic [N-1:0] start_of(input logic [N-1:0] m, input logic dir_up);
    return dir_up ? '0 : m - N'(1);
  endfunction

  // A write in a commit cycle bypasses m_pend so the fresh modulus applies at once.
  assign wr_ok        = bus.m_wr && (bus.m_val != '0);
  assign m_next       = wr_ok ? bus.m_val : m_pend_q;
  assign m_last       = m_cur_q - N'(1);
  assign term_val     = bus.up ? m_last : '0;
  assign at_term      = (q_q == term_val);
  assign load_clamped = (bus.load_val > m_last) ? m_last : bus.load_val;

  always_comb begin
    q_d      = q_q;
    state_d  = state_q;
    m_pend_d = m_next;
    m_cur_d  = m_cur_q;
    commit   = 1'b0;
    if (bus.clr) begin
      commit  = 1'b1;
      q_d     = start_of(m_next, bus.up);
      state_d = ST_RUN;
    end else if (bus.load) begin
      q_d = load_clamped;
      if (state_q == ST_DONE && bus.mode == MODE_WRAP) state_d = ST_RUN;
    end else if (state_q == ST_DONE) begin
      if (bus.start) begin
        commit  = 1'b1;
        q_d     = start_of(m_next, bus.up);
        state_d = ST_RUN;
      end else if (bus.mode == MODE_WRAP) begin
        state_d = ST_RUN;
      end
    end else if (bus.en) begin
      if (!at_term) begin
        q_d = bus.up ? q_q + N'(1) : q_q - N'(1);
      end else if (bus.mode == MODE_WRAP) begin
        commit = 1'b1;
        q_d    = start_of(m_next, bus.up);
      end else begin
        state_d = ST_DONE;
      end
    end
    if (commit) m_cur_d = m_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q      <= '0;
      m_cur_q  <= M_RST;
      m_pend_q <= M_RST;
      state_q  <= ST_RUN;
    end else begin
      q_q      <= q_d;
      m_cur_q  <= m_cur_d;
      m_pend_q <= m_pend_d;
      state_q  <= state_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.m_cur     = m_cur_q;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.max_tick  = at_term;
  assign bus.term_tick = at_term && bus.en && (state_q == ST_RUN);

endmodule

// File: tb/tb_prog_mod_counter.sv
// Directed bench for prog_mod_counter: wrap, modulus shadowing, down/one-shot, priority,
// edge cases, async reset and a two-stage cascade.
module tb_prog_mod_counter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  prog_mod_counter_if #(.N(8)) bus0 ();
  prog_mod_counter_if #(.N(8)) bus1 ();

  prog_mod_counter #(.N(8), .M_DEFAULT(10)) u_lo (.clk(clk), .reset(reset), .bus(bus0));
  prog_mod_counter #(.N(8), .M_DEFAULT(10)) u_hi (.clk(clk), .reset(reset), .bus(bus1));

  assign bus1.en = bus0.term_tick;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_controls();
    bus0.en = 1'b0; bus0.up = 1'b1; bus0.clr = 1'b0; bus0.load = 1'b0; bus0.load_val = '0;
    bus0.m_wr = 1'b0; bus0.m_val = '0; bus0.mode = 1'b0; bus0.start = 1'b0;
    bus1.up = 1'b1; bus1.clr = 1'b0; bus1.load = 1'b0; bus1.load_val = '0;
    bus1.m_wr = 1'b0; bus1.m_val = '0; bus1.mode = 1'b0; bus1.start = 1'b0;
  endtask

  task automatic test_reset();
    idle_controls();
    reset = 1'b1;
    #1;
    checks++; if (bus0.q !== 8'd0) begin errors++; $display("FAIL reset_q got %0d exp 0", bus0.q); end
    checks++; if (bus0.m_cur !== 8'd10) begin errors++; $display("FAIL reset_m_cur got %0d exp 10", bus0.m_cur); end
    checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", bus0.busy); end
    checks++; if (bus0.max_tick !== 1'b0) begin errors++; $display("FAIL reset_max_tick got %b exp 0", bus0.max_tick); end
    checks++; if (bus0.term_tick !== 1'b0) begin errors++; $display("FAIL reset_term_tick got %b exp 0", bus0.term_tick); end
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_wrap();
    bus0.en = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      checks++; if (bus0.q !== 8'(i % 10)) begin errors++; $display("FAIL wrap_q i=%0d got %0d exp %0d", i, bus0.q, i % 10); end
      checks++; if (bus0.max_tick !== (i % 10 == 9)) begin errors++; $display("FAIL wrap_max i=%0d got %b", i, bus0.max_tick); end
      checks++; if (bus0.term_tick !== (i % 10 == 9)) begin errors++; $display("FAIL wrap_term i=%0d got %b", i, bus0.term_tick); end
      step();
    end
  endtask

  task automatic test_mod_change();
    repeat (3) step();
    bus0.m_wr = 1'b1; bus0.m_val = 8'd4;
    step();
    bus0.m_wr = 1'b0; bus0.m_val = 8'd0;
    #1;
    for (int k = 4; k <= 9; k++) begin
      checks++; if (bus0.q !== 8'(k)) begin errors++; $display("FAIL modchg_q got %0d exp %0d", bus0.q, k); end
      checks++; if (bus0.m_cur !== 8'd10) begin errors++; $display("FAIL modchg_m_old got %0d exp 10", bus0.m_cur); end
      step();
    end
    for (int k = 0; k < 8; k++) begin
      checks++; if (bus0.q !== 8'(k % 4)) begin errors++; $display("FAIL modchg_new_q got %0d exp %0d", bus0.q, k % 4); end
      checks++; if (bus0.m_cur !== 8'd4) begin errors++; $display("FAIL modchg_m_new got %0d exp 4", bus0.m_cur); end
      step();
    end
  endtask

  task automatic test_down_oneshot();
    bus0.mode = 1'b1; bus0.up = 1'b0; bus0.m_wr = 1'b1; bus0.m_val = 8'd5; bus0.clr = 1'b1;
    step();
    bus0.m_wr = 1'b0; bus0.m_val = 8'd0; bus0.clr = 1'b0;
    #1;
    checks++; if (bus0.m_cur !== 8'd5) begin errors++; $display("FAIL oneshot_m_cur got %0d exp 5", bus0.m_cur); end
    for (int k = 4; k >= 0; k--) begin
      checks++; if (bus0.q !== 8'(k)) begin errors++; $display("FAIL oneshot_q got %0d exp %0d", bus0.q, k); end
      checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL oneshot_busy got %b exp 1", bus0.busy); end
      checks++; if (bus0.term_tick !== (k == 0)) begin errors++; $display("FAIL oneshot_term k=%0d got %b", k, bus0.term_tick); end
      step();
    end
    repeat (2) begin
      checks++; if (bus0.q !== 8'd0) begin errors++; $display("FAIL done_q got %0d exp 0", bus0.q); end
      checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL done_busy got %b exp 0", bus0.busy); end
      checks++; if (bus0.term_tick !== 1'b0) begin errors++; $display("FAIL done_term got %b exp 0", bus0.term_tick); end
      step();
    end
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    #1;
    checks++; if (bus0.q !== 8'd4) begin errors++; $display("FAIL restart_q got %0d exp 4", bus0.q); end
    checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b exp 1", bus0.busy); end
  endtask

  task automatic test_priority_clamp();
    bus0.mode = 1'b0; bus0.up = 1'b0; bus0.m_wr = 1'b1; bus0.m_val = 8'd10;
    bus0.clr = 1'b1; bus0.load = 1'b1; bus0.load_val = 8'd3;
    step();
    bus0.m_wr = 1'b0; bus0.m_val = 8'd0; bus0.clr = 1'b0;
    bus0.up = 1'b1; bus0.en = 1'b0; bus0.load_val = 8'd200;
    checks++; if (bus0.q !== 8'd9) begin errors++; $display("FAIL prio_clr_load got %0d exp 9", bus0.q); end
    checks++; if (bus0.m_cur !== 8'd10) begin errors++; $display("FAIL prio_m_cur got %0d exp 10", bus0.m_cur); end
    bus0.clr = 1'b0;
    step();
    checks++; if (bus0.q !== 8'd9) begin errors++; $display("FAIL clamp_q got %0d exp 9", bus0.q); end
    bus0.load_val = 8'd5;
    step();
    bus0.load = 1'b0;
    checks++; if (bus0.q !== 8'd5) begin errors++; $display("FAIL load_q got %0d exp 5", bus0.q); end
    step();
    checks++; if (bus0.q !== 8'd5) begin errors++; $display("FAIL load_hold got %0d exp 5", bus0.q); end
  endtask

  task automatic test_m_val_zero();
    bus0.m_wr = 1'b1; bus0.m_val = 8'd0; bus0.clr = 1'b1;
    step();
    bus0.clr = 1'b0;
    checks++; if (bus0.m_cur !== 8'd10) begin errors++; $display("FAIL mzero_direct got %0d exp 10", bus0.m_cur); end
    checks++; if (bus0.q !== 8'd0) begin errors++; $display("FAIL mzero_q got %0d exp 0", bus0.q); end
    step();
    bus0.m_wr = 1'b0; bus0.clr = 1'b1;
    step();
    bus0.clr = 1'b0;
    checks++; if (bus0.m_cur !== 8'd10) begin errors++; $display("FAIL mzero_pend got %0d exp 10", bus0.m_cur); end
  endtask

  task automatic test_mod_one();
    bus0.m_wr = 1'b1; bus0.m_val = 8'd1; bus0.clr = 1'b1; bus0.en = 1'b1; bus0.up = 1'b1;
    step();
    bus0.m_wr = 1'b0; bus0.m_val = 8'd0; bus0.clr = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus0.q !== 8'd0) begin errors++; $display("FAIL m1_q got %0d exp 0", bus0.q); end
      checks++; if (bus0.max_tick !== 1'b1) begin errors++; $display("FAIL m1_max got %b exp 1", bus0.max_tick); end
      checks++; if (bus0.term_tick !== 1'b1) begin errors++; $display("FAIL m1_term got %b exp 1", bus0.term_tick); end
      step();
    end
    bus0.en = 1'b0;
    #1;
    checks++; if (bus0.term_tick !== 1'b0) begin errors++; $display("FAIL m1_term_off got %b exp 0", bus0.term_tick); end
    checks++; if (bus0.max_tick !== 1'b1) begin errors++; $display("FAIL m1_max_off got %b exp 1", bus0.max_tick); end
    bus0.mode = 1'b1; bus0.en = 1'b1;
    #1;
    checks++; if (bus0.term_tick !== 1'b1) begin errors++; $display("FAIL m1_os_term got %b exp 1", bus0.term_tick); end
    step();
    checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL m1_os_done got %b exp 0", bus0.busy); end
    bus0.mode = 1'b0;
    step();
    checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL mode_release got %b exp 1", bus0.busy); end
    checks++; if (bus0.q !== 8'd0) begin errors++; $display("FAIL mode_release_q got %0d exp 0", bus0.q); end
  endtask

  task automatic test_en_toggle();
    bus0.m_wr = 1'b1; bus0.m_val = 8'd10; bus0.clr = 1'b1;
    step();
    bus0.m_wr = 1'b0; bus0.m_val = 8'd0; bus0.clr = 1'b0;
    step();
    step();
    checks++; if (bus0.q !== 8'd2) begin errors++; $display("FAIL en_run got %0d exp 2", bus0.q); end
    bus0.en = 1'b0;
    #1;
    checks++; if (bus0.term_tick !== 1'b0) begin errors++; $display("FAIL en_off_term got %b exp 0", bus0.term_tick); end
    step();
    step();
    checks++; if (bus0.q !== 8'd2) begin errors++; $display("FAIL en_hold got %0d exp 2", bus0.q); end
    bus0.en = 1'b1;
    step();
    checks++; if (bus0.q !== 8'd3) begin errors++; $display("FAIL en_resume got %0d exp 3", bus0.q); end
    bus0.load = 1'b1; bus0.load_val = 8'd9;
    step();
    bus0.load = 1'b0; bus0.en = 1'b0;
    #1;
    checks++; if (bus0.max_tick !== 1'b1) begin errors++; $display("FAIL en_term_max got %b exp 1", bus0.max_tick); end
    checks++; if (bus0.term_tick !== 1'b0) begin errors++; $display("FAIL en_term_gated got %b exp 0", bus0.term_tick); end
    step();
    checks++; if (bus0.q !== 8'd9) begin errors++; $display("FAIL en_term_hold got %0d exp 9", bus0.q); end
    bus0.en = 1'b1;
    #1;
    checks++; if (bus0.term_tick !== 1'b1) begin errors++; $display("FAIL en_term_on got %b exp 1", bus0.term_tick); end
    step();
    checks++; if (bus0.q !== 8'd0) begin errors++; $display("FAIL en_wrap got %0d exp 0", bus0.q); end
  endtask

  task automatic test_async_reset();
    repeat (5) step();
    bus0.m_wr = 1'b1; bus0.m_val = 8'd3;
    step();
    bus0.m_wr = 1'b0; bus0.m_val = 8'd0;
    checks++; if (bus0.q !== 8'd6) begin errors++; $display("FAIL ar_pre_q got %0d exp 6", bus0.q); end
    checks++; if (bus0.m_cur !== 8'd10) begin errors++; $display("FAIL ar_pre_m got %0d exp 10", bus0.m_cur); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (bus0.q !== 8'd0) begin errors++; $display("FAIL ar_q got %0d exp 0", bus0.q); end
    checks++; if (bus0.m_cur !== 8'd10) begin errors++; $display("FAIL ar_m got %0d exp 10", bus0.m_cur); end
    step();
    reset = 1'b0;
    bus0.clr = 1'b1;
    step();
    bus0.clr = 1'b0;
    checks++; if (bus0.m_cur !== 8'd10) begin errors++; $display("FAIL ar_pend_discard got %0d exp 10", bus0.m_cur); end
    checks++; if (bus0.q !== 8'd0) begin errors++; $display("FAIL ar_post_q got %0d exp 0", bus0.q); end
  endtask

  task automatic test_cascade();
    int value;
    idle_controls();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus0.en = 1'b1;
    #1;
    for (int i = 0; i < 105; i++) begin
      value = 10 * int'(bus1.q) + int'(bus0.q);
      checks++; if (value !== i % 100) begin errors++; $display("FAIL cascade i=%0d got %0d exp %0d", i, value, i % 100); end
      if (i % 100 == 99) begin
        checks++; if (bus1.term_tick !== 1'b1) begin errors++; $display("FAIL cascade_carry got %b exp 1", bus1.term_tick); end
      end
      step();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_wrap();
    test_mod_change();
    test_down_oneshot();
    test_priority_clamp();
    test_m_val_zero();
    test_mod_one();
    test_en_toggle();
    test_async_reset();
    test_cascade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
